// File: rtl/ifetch_prefetch_unit.sv
// Instruction fetch / prefetch stage.
// Owns the fetch PC and keeps at most one request outstanding on a req/gnt/rvalid
// instruction memory port. Returned words are queued with their PCs in a small
// FIFO that feeds decode over valid/ready. A redirect flushes the FIFO, and any
// response still in flight for the old path is discarded.
module ifetch_prefetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    // S_WAIT expects a response for the current path, S_DROP expects one to discard
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t           state;
    state_t           state_next;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  redirect_tgt;
    logic [XLEN-1:0]  fifo_data [DEPTH];
    logic [XLEN-1:0]  fifo_pc   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             req_fire;
    logic             push;
    logic             pop;

    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_addr    = fetch_pc;
    assign inst_valid   = (count != '0);
    assign pop          = inst_valid && inst_ready;
    assign inst_data    = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc      = inst_valid ? fifo_pc[rd_ptr]   : '0;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus request/push decode; a full FIFO simply withholds the request
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        req_fire   = 1'b0;
        push       = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = !reset && (count < FULL_CNT);
                req_fire = imem_req && imem_gnt;
                if (req_fire) begin
                    // a grant alongside a redirect belongs to the old path
                    state_next = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push       = !redirect_valid;
                    state_next = S_REQ;
                end else if (redirect_valid) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Fetch PC, in-flight request PC and FIFO bookkeeping; redirect wins over everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_tgt;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage; contents are only visible through count, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Directed bench for ifetch_prefetch_unit with a behavioural instruction memory
// that grants on request and answers addr ^ 32'hA5A5_0000 after rsp_delay cycles.
module tb_ifetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // memory model controls and state
    int          rsp_delay = 1;
    bit          gnt_en    = 1'b1;
    bit          pend      = 1'b0;
    int          wcnt      = 0;
    logic [31:0] paddr     = 32'd0;

    // observation logs: granted addresses, popped pcs/data
    logic [31:0] gq[$];
    logic [31:0] pq_pc[$];
    logic [31:0] pq_data[$];

    ifetch_prefetch_unit #(
        .XLEN(32),
        .DEPTH(4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model and monitor: decides gnt/rvalid for the coming rising edge
    always begin
        @(negedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (reset) begin
            pend     = 1'b0;
            imem_gnt = 1'b0;
        end else begin
            if (pend) begin
                wcnt--;
                if (wcnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = paddr ^ 32'hA5A5_0000;
                    pend        = 1'b0;
                end
            end
            imem_gnt = gnt_en;
            if (imem_req && imem_gnt) begin
                pend  = 1'b1;
                wcnt  = rsp_delay;
                paddr = imem_addr;
                gq.push_back(imem_addr);
            end
            if (inst_valid && inst_ready) begin
                pq_pc.push_back(inst_pc);
                pq_data.push_back(inst_data);
            end
        end
    end

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // reset for two cycles, clear logs, release on a falling edge
    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick(2);
        gq.delete();
        pq_pc.delete();
        pq_data.delete();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b1;
        tick(2);

        // values held during reset
        check("rst_req",   32'(imem_req),   32'd0);
        check("rst_addr",  imem_addr,       32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_data",  inst_data,       32'h0);
        check("rst_pc",    inst_pc,         32'h0);

        // streaming fetch, 1-cycle memory, decode always ready
        gq.delete();
        reset = 1'b0;
        tick(1);
        check("t1_valid_early", 32'(inst_valid), 32'd0);
        tick(1);
        check("t1_valid_first", 32'(inst_valid), 32'd1);
        check("t1_pc_first",    inst_pc,         32'h0);
        check("t1_data_first",  inst_data,       32'hA5A5_0000);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr",  qat(gq, i),      32'(4 * i));
            check("t1_pc",    qat(pq_pc, i),   32'(4 * i));
            check("t1_data",  qat(pq_data, i), 32'(4 * i) ^ 32'hA5A5_0000);
        end

        // back-pressure fills the FIFO, then drain
        inst_ready = 1'b0;
        do_reset();
        tick(20);
        check("t2_nreq",  32'(gq.size()),   32'd4);
        check("t2_req",   32'(imem_req),    32'd0);
        check("t2_valid", 32'(inst_valid),  32'd1);
        check("t2_head",  inst_pc,          32'h0);
        inst_ready = 1'b1;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_pc", qat(pq_pc, i), 32'(4 * i));
        end
        check("t2_resume", qat(gq, 4), 32'h10);

        // redirect while waiting on a slow response
        rsp_delay = 3;
        do_reset();
        tick(1);
        check("t3_wait_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick(1);
        redirect_valid = 1'b0;
        check("t3_drop_req",   32'(imem_req),   32'd0);
        check("t3_drop_valid", 32'(inst_valid), 32'd0);
        tick(12);
        check("t3_addr0", qat(gq, 0),      32'h0);
        check("t3_addr1", qat(gq, 1),      32'h100);
        check("t3_pc0",   qat(pq_pc, 0),   32'h100);
        check("t3_data0", qat(pq_data, 0), 32'hA5A5_0100);

        // redirect coinciding with the grant for 0x8
        rsp_delay = 1;
        do_reset();
        tick(4);
        check("t4_req",  32'(imem_req), 32'd1);
        check("t4_addr", imem_addr,     32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick(1);
        redirect_valid = 1'b0;
        check("t4_drop_req",   32'(imem_req),   32'd0);
        check("t4_drop_valid", 32'(inst_valid), 32'd0);
        tick(10);
        check("t4_addr2", qat(gq, 2),    32'h8);
        check("t4_addr3", qat(gq, 3),    32'h200);
        check("t4_pc0",   qat(pq_pc, 0), 32'h0);
        check("t4_pc1",   qat(pq_pc, 1), 32'h4);
        check("t4_pc2",   qat(pq_pc, 2), 32'h200);

        // redirect near the top of memory, low bits masked, PC wraps to 0
        gnt_en = 1'b0;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        tick(1);
        redirect_valid = 1'b0;
        gnt_en         = 1'b1;
        check("t5_req",  32'(imem_req), 32'd1);
        check("t5_addr", imem_addr,     32'hFFFF_FFF8);
        tick(12);
        check("t5_pc0",   qat(pq_pc, 0),   32'hFFFF_FFF8);
        check("t5_pc1",   qat(pq_pc, 1),   32'hFFFF_FFFC);
        check("t5_pc2",   qat(pq_pc, 2),   32'h0000_0000);
        check("t5_data0", qat(pq_data, 0), 32'h5A5A_FFF8);
        check("t5_data2", qat(pq_data, 2), 32'hA5A5_0000);

        // reset with two entries buffered and a request outstanding
        inst_ready = 1'b0;
        do_reset();
        tick(5);
        check("t6_pre_valid", 32'(inst_valid), 32'd1);
        check("t6_pre_pc",    inst_pc,         32'h0);
        check("t6_pre_req",   32'(imem_req),   32'd0);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(inst_valid), 32'd0);
        check("t6_rst_req",   32'(imem_req),   32'd0);
        check("t6_rst_pc",    inst_pc,         32'h0);
        check("t6_rst_data",  inst_data,       32'h0);
        check("t6_rst_addr",  imem_addr,       32'h0);
        tick(2);
        gq.delete();
        pq_pc.delete();
        pq_data.delete();
        inst_ready = 1'b1;
        reset      = 1'b0;
        tick(4);
        check("t6_addr0", qat(gq, 0),    32'h0);
        check("t6_pc0",   qat(pq_pc, 0), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
